// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the generic FIFO-monitor control FSM:
// state encodings, state width and default parameter values.
package ctrl_fsm_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_NUM_FIFOS   = 5;
    localparam int DEF_NUM_TH      = 3;
    localparam int DEF_TH_W        = 3;
    localparam int DEF_IDLE_CYCLES = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

endpackage

// File: rtl/gen_ctrl_fsm_if.sv
// Bus bundle between the FIFO subsystem (master) and the control FSM (slave).
interface gen_ctrl_fsm_if
    import ctrl_fsm_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int NUM_TH    = DEF_NUM_TH,
    parameter int TH_W      = DEF_TH_W
);
    logic                   init;
    logic                   err_clr;
    logic [NUM_FIFOS-1:0]   fifo_errors;
    logic [NUM_FIFOS-1:0]   fifo_empties;
    logic [NUM_FIFOS-1:0]   err_mask;
    logic [NUM_TH*TH_W-1:0] af_in;
    logic [NUM_TH*TH_W-1:0] ae_in;
    logic [NUM_TH*TH_W-1:0] af_out;
    logic [NUM_TH*TH_W-1:0] ae_out;
    logic [NUM_FIFOS-1:0]   error_out;
    logic                   active_out;
    logic                   idle_out;
    logic                   cfg_err_out;
    logic [STATE_W-1:0]     state_out;

    modport master (
        output init, err_clr, fifo_errors, fifo_empties, err_mask, af_in, ae_in,
        input  af_out, ae_out, error_out, active_out, idle_out, cfg_err_out, state_out
    );

    modport slave (
        input  init, err_clr, fifo_errors, fifo_empties, err_mask, af_in, ae_in,
        output af_out, ae_out, error_out, active_out, idle_out, cfg_err_out, state_out
    );

endinterface

// File: rtl/empty_qual_cnt.sv
// Counts consecutive all-empty cycles while enabled; done fires on the
// cycle that completes IDLE_CYCLES of them, and the count restarts.
module empty_qual_cnt
    import ctrl_fsm_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic clk,
    input  logic reset_L,
    input  logic en,
    input  logic all_empty,
    output logic done
);
    localparam logic [3:0] LAST = 4'(IDLE_CYCLES - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign done = en && all_empty && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 4'd1;
        if (!en || !all_empty || done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gen_ctrl_fsm.sv
// Control FSM supervising a set of FIFOs: threshold configuration,
// idle/active tracking and sticky error capture. All outputs are Moore-registered.
module gen_ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int NUM_FIFOS   = DEF_NUM_FIFOS,
    parameter int NUM_TH      = DEF_NUM_TH,
    parameter int TH_W        = DEF_TH_W,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic          clk,
    input  logic          reset_L,
    gen_ctrl_fsm_if.slave bus
);
    localparam int THV_W = NUM_TH * TH_W;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rst_n;

    state_e               state_q, state_d;
    logic [THV_W-1:0]     af_q, af_d;
    logic [THV_W-1:0]     ae_q, ae_d;
    logic [NUM_FIFOS-1:0] err_q, err_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 idle_q, idle_d;
    logic                 active_q, active_d;

    logic [NUM_FIFOS-1:0] eff_err;
    logic                 all_empty;
    logic                 cfg_bad_now;
    logic                 qual_done;

    function automatic logic cfg_bad(input logic [THV_W-1:0] af, input logic [THV_W-1:0] ae);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_TH; k++) begin
            if (af[k*TH_W +: TH_W] <= ae[k*TH_W +: TH_W]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Assertion is immediate; release only after two clean edges.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

    assign rst_n       = sync2_q;
    assign eff_err     = bus.fifo_errors & ~bus.err_mask;
    assign all_empty   = &bus.fifo_empties;
    assign cfg_bad_now = cfg_bad(bus.af_in, bus.ae_in);

    empty_qual_cnt #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_qual (
        .clk       (clk),
        .reset_L   (rst_n),
        .en        (state_q == ST_ACTIVE),
        .all_empty (all_empty),
        .done      (qual_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            af_q      <= '0;
            ae_q      <= '0;
            err_q     <= '0;
            cfg_err_q <= 1'b0;
            idle_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_err_d;
            idle_q    <= idle_d;
            active_q  <= active_d;
        end
    end

    // Errors outrank reconfiguration, which outranks the empty rules.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!bus.init && !cfg_bad_now) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (eff_err != '0)      state_d = ST_ERROR;
                else if (bus.init)      state_d = ST_INIT;
                else if (!all_empty)    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (eff_err != '0)      state_d = ST_ERROR;
                else if (bus.init)      state_d = ST_INIT;
                else if (qual_done)     state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.err_clr)        state_d = ST_INIT;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        af_d      = af_q;
        ae_d      = ae_q;
        err_d     = '0;
        cfg_err_d = (state_d == ST_INIT) && cfg_bad_now;
        idle_d    = (state_d == ST_IDLE);
        active_d  = (state_d == ST_ACTIVE);
        if (state_q == ST_INIT) begin
            af_d = bus.af_in;
            ae_d = bus.ae_in;
        end
        if (state_d == ST_ERROR) begin
            err_d = (state_q == ST_ERROR) ? (err_q | eff_err) : eff_err;
        end
    end

    assign bus.state_out   = state_q;
    assign bus.af_out      = af_q;
    assign bus.ae_out      = ae_q;
    assign bus.error_out   = err_q;
    assign bus.cfg_err_out = cfg_err_q;
    assign bus.idle_out    = idle_q;
    assign bus.active_out  = active_q;

endmodule

// File: tb/tb_gen_ctrl_fsm.sv
// Scenario bench for gen_ctrl_fsm: expected outputs are queued as each cycle
// of stimulus is applied and compared once the DUT has produced that cycle.
module tb_gen_ctrl_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       idle;
        logic       act;
        logic       cfg;
        logic [4:0] err;
        logic [8:0] af;
        logic [8:0] ae;
    } obs_t;

    typedef struct packed {
        logic       init;
        logic       clr;
        logic [4:0] errs;
        logic [4:0] empt;
        logic [4:0] mask;
        logic [8:0] afi;
        logic [8:0] aei;
        obs_t       e;
    } row_t;

    localparam logic [8:0] T6  = 9'o666;
    localparam logic [8:0] T3  = 9'o333;
    localparam logic [8:0] BAF = 9'o626;
    localparam logic [8:0] BAE = 9'o323;
    localparam logic [8:0] GAF = 9'o676;

    logic clk = 1'b0;
    logic reset_L = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    gen_ctrl_fsm_if #(.NUM_FIFOS(5), .NUM_TH(3), .TH_W(3)) bus ();

    gen_ctrl_fsm #(
        .NUM_FIFOS   (5),
        .NUM_TH      (3),
        .TH_W        (3),
        .IDLE_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    function automatic obs_t mk(input logic [2:0] st, input logic cfg, input logic [4:0] err,
                                input logic [8:0] af, input logic [8:0] ae);
        obs_t o;
        o.st = st; o.idle = (st == 3'd2); o.act = (st == 3'd3);
        o.cfg = cfg; o.err = err; o.af = af; o.ae = ae;
        return o;
    endfunction

    function automatic row_t mkrow(input logic init, input logic clr, input logic [4:0] errs,
                                   input logic [4:0] empt, input logic [4:0] mask,
                                   input logic [8:0] afi, input logic [8:0] aei, input obs_t e);
        row_t r;
        r.init = init; r.clr = clr; r.errs = errs; r.empt = empt; r.mask = mask;
        r.afi = afi; r.aei = aei; r.e = e;
        return r;
    endfunction

    function automatic obs_t sample();
        return {bus.state_out, bus.idle_out, bus.active_out, bus.cfg_err_out,
                bus.error_out, bus.af_out, bus.ae_out};
    endfunction

    task automatic drive(input row_t r);
        bus.init = r.init; bus.err_clr = r.clr; bus.fifo_errors = r.errs;
        bus.fifo_empties = r.empt; bus.err_mask = r.mask;
        bus.af_in = r.afi; bus.ae_in = r.aei;
    endtask

    task automatic test_reset();
        row_t r[$];
        obs_t e, got;
        drive(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0)));
        #2 reset_L = 1'b0;
        exp_q.push_back(mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0));
        #1;
        e = exp_q.pop_front(); got = sample();
        n_assert++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_async got=%h required=%h", got, e);
        end
        #20 reset_L = 1'b1;
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0)));
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0)));
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd1, 1'b0, 5'b0, 9'd0, 9'd0)));
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd1, 1'b0, 5'b0, T6, T3)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd2, 1'b0, 5'b0, T6, T3)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd2, 1'b0, 5'b0, T6, T3)));
        foreach (r[i]) begin
            drive(r[i]); exp_q.push_back(r[i].e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = sample();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_seq[%0d] got st=%0d idle=%b err=%b af=%o ae=%o required st=%0d idle=%b err=%b af=%o ae=%o",
                         i, got.st, got.idle, got.err, got.af, got.ae, e.st, e.idle, e.err, e.af, e.ae);
            end
        end
    endtask

    task automatic test_cfg();
        row_t r[$];
        obs_t e, got;
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, BAF, BAE, mk(3'd1, 1'b1, 5'b0, T6, T3)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, BAF, BAE, mk(3'd1, 1'b1, 5'b0, BAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, BAF, BAE, mk(3'd1, 1'b1, 5'b0, BAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, GAF, BAE, mk(3'd2, 1'b0, 5'b0, GAF, BAE)));
        foreach (r[i]) begin
            drive(r[i]); exp_q.push_back(r[i].e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = sample();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cfg[%0d] got st=%0d cfg=%b af=%o ae=%o required st=%0d cfg=%b af=%o ae=%o",
                         i, got.st, got.cfg, got.af, got.ae, e.st, e.cfg, e.af, e.ae);
            end
        end
    endtask

    task automatic test_active();
        row_t r[$];
        obs_t e, got;
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11110, 5'b0, GAF, BAE, mk(3'd3, 1'b0, 5'b0, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, GAF, BAE, mk(3'd3, 1'b0, 5'b0, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b01111, 5'b0, GAF, BAE, mk(3'd3, 1'b0, 5'b0, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, GAF, BAE, mk(3'd3, 1'b0, 5'b0, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, GAF, BAE, mk(3'd2, 1'b0, 5'b0, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11110, 5'b0, GAF, BAE, mk(3'd3, 1'b0, 5'b0, GAF, BAE)));
        foreach (r[i]) begin
            drive(r[i]); exp_q.push_back(r[i].e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = sample();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL active[%0d] got st=%0d idle=%b act=%b required st=%0d idle=%b act=%b",
                         i, got.st, got.idle, got.act, e.st, e.idle, e.act);
            end
        end
    endtask

    task automatic test_error();
        row_t r[$];
        obs_t e, got;
        r.push_back(mkrow(1'b0, 1'b0, 5'b10001, 5'b11110, 5'b00001, GAF, BAE, mk(3'd4, 1'b0, 5'b10000, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b00000, 5'b11110, 5'b00001, GAF, BAE, mk(3'd4, 1'b0, 5'b10000, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b00010, 5'b11110, 5'b00001, GAF, BAE, mk(3'd4, 1'b0, 5'b10010, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b00001, 5'b11110, 5'b00001, GAF, BAE, mk(3'd4, 1'b0, 5'b10010, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b1, 5'b00000, 5'b11111, 5'b00001, GAF, BAE, mk(3'd1, 1'b0, 5'b00000, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b00000, 5'b11111, 5'b00000, GAF, BAE, mk(3'd2, 1'b0, 5'b00000, GAF, BAE)));
        foreach (r[i]) begin
            drive(r[i]); exp_q.push_back(r[i].e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = sample();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL error[%0d] got st=%0d err=%b required st=%0d err=%b",
                         i, got.st, got.err, e.st, e.err);
            end
        end
    endtask

    task automatic test_priority();
        row_t r[$];
        obs_t e, got;
        r.push_back(mkrow(1'b0, 1'b0, 5'b00001, 5'b11111, 5'b00001, GAF, BAE, mk(3'd2, 1'b0, 5'b00000, GAF, BAE)));
        r.push_back(mkrow(1'b1, 1'b0, 5'b00100, 5'b11111, 5'b00000, GAF, BAE, mk(3'd4, 1'b0, 5'b00100, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b1, 5'b01000, 5'b11111, 5'b00000, GAF, BAE, mk(3'd1, 1'b0, 5'b00000, GAF, BAE)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b00000, 5'b11111, 5'b00000, GAF, BAE, mk(3'd2, 1'b0, 5'b00000, GAF, BAE)));
        foreach (r[i]) begin
            drive(r[i]); exp_q.push_back(r[i].e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = sample();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL priority[%0d] got st=%0d err=%b required st=%0d err=%b",
                         i, got.st, got.err, e.st, e.err);
            end
        end
    endtask

    task automatic test_reset_midop();
        row_t r[$];
        obs_t e, got;
        drive(mkrow(1'b0, 1'b0, 5'b0, 5'b11110, 5'b0, GAF, BAE, mk(3'd3, 1'b0, 5'b0, GAF, BAE)));
        exp_q.push_back(mk(3'd3, 1'b0, 5'b0, GAF, BAE));
        @(posedge clk); #1;
        e = exp_q.pop_front(); got = sample();
        n_assert++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL midop_active got=%h required=%h", got, e);
        end
        #3 reset_L = 1'b0;
        exp_q.push_back(mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0));
        #1;
        e = exp_q.pop_front(); got = sample();
        n_assert++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL midop_async got=%h required=%h", got, e);
        end
        #3 reset_L = 1'b1;
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0)));
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd0, 1'b0, 5'b0, 9'd0, 9'd0)));
        r.push_back(mkrow(1'b1, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd1, 1'b0, 5'b0, 9'd0, 9'd0)));
        r.push_back(mkrow(1'b0, 1'b0, 5'b0, 5'b11111, 5'b0, T6, T3, mk(3'd2, 1'b0, 5'b0, T6, T3)));
        foreach (r[i]) begin
            drive(r[i]); exp_q.push_back(r[i].e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = sample();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL midop_seq[%0d] got st=%0d af=%o ae=%o required st=%0d af=%o ae=%o",
                         i, got.st, got.af, got.ae, e.st, e.af, e.ae);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_active();
        test_error();
        test_priority();
        test_reset_midop();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
